// File: rtl/modulo_datapath_contador_if.sv
// Handshake/bus bundle between the control FSM and the counting datapath.
interface modulo_datapath_contador_if;
    localparam int unsigned DW = 8;

    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          Enable_C;
    logic          Load_C;
    logic          Clear_Reg;
    logic          Load_Reg;
    logic          EmptyBuffer;
    logic [DW-1:0] count;
    logic          done;
    logic          full;
    logic          ovf;

    modport master (
        output wr_en, wr_data, Enable_C, Load_C, Clear_Reg,
        input  Load_Reg, EmptyBuffer, count, done, full, ovf
    );

    modport slave (
        input  wr_en, wr_data, Enable_C, Load_C, Clear_Reg,
        output Load_Reg, EmptyBuffer, count, done, full, ovf
    );
endinterface

// File: rtl/modulo_datapath_contador.sv
// Counting datapath: 4-deep input FIFO feeding a holding register that loads
// a down-counter; done pulses when a decrement lands on zero.
module modulo_datapath_contador (
    input  logic                        clk,
    input  logic                        rst,
    modulo_datapath_contador_if.slave   bus
);
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned OW    = 3;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [DW-1:0] reg_q, reg_d;
    logic          load_reg_q, load_reg_d;
    logic [DW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    // FIFO, holding register and counter next-state
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        reg_d      = reg_q;
        load_reg_d = load_reg_q;
        count_d    = count_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        // A release edge never pops; the refill happens one edge later.
        pop  = !load_reg_q && (occ_q != OW'(0)) && !bus.Clear_Reg;
        push = bus.wr_en && ((occ_q != OW'(DEPTH)) || pop);

        if (push) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            reg_d      = mem_q[rd_ptr_q];
            load_reg_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end
        if (bus.Clear_Reg) begin
            reg_d      = '0;
            load_reg_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (bus.wr_en && !push) begin
            ovf_d = 1'b1;
        end

        // Load wins over decrement; decrement saturates at zero.
        if (bus.Load_C) begin
            count_d = load_reg_q ? reg_q : '0;
        end else if (bus.Enable_C && (count_q != DW'(0))) begin
            count_d = count_q - DW'(1);
            done_d  = (count_q == DW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            reg_q      <= '0;
            load_reg_q <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            reg_q      <= reg_d;
            load_reg_q <= load_reg_d;
            count_q    <= count_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.Load_Reg    = load_reg_q;
    assign bus.count       = count_q;
    assign bus.done        = done_q;
    assign bus.ovf         = ovf_q;
    assign bus.EmptyBuffer = (count_q == DW'(0));
    assign bus.full        = (occ_q == OW'(DEPTH));
endmodule

// File: doc/modulo_datapath_contador.md
MODULO_DATAPATH_CONTADOR -- requirements
Module: modulo_datapath_contador

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL provide port wr_en  input  1  push request for wr_data into the input FIFO.
REQ-005 SHALL provide port wr_data  input  8  value to be counted.
REQ-006 SHALL provide port Enable_C  input  1  counter decrement strobe from the control FSM.
REQ-007 SHALL provide port Load_C  input  1  counter load strobe from the control FSM (counter <= register).
REQ-008 SHALL provide port Clear_Reg  input  1  register release strobe from the control FSM.
REQ-009 SHALL provide port Load_Reg  output  1  register holds a valid value.
REQ-010 SHALL provide port EmptyBuffer  output  1  counter value equals zero.
REQ-011 SHALL provide port count  output  8  current counter value.
REQ-012 SHALL provide port done  output  1  one-cycle pulse when a decrement reaches zero.
REQ-013 SHALL provide port full  output  1  input FIFO holds 4 entries.
REQ-014 SHALL provide port ovf  output  1  sticky flag, set when a push is attempted while full.

Function
REQ-015 SHALL contain a 4-entry x 8-bit FIFO with 2-bit read/write pointers wrapping 3->0 and a 3-bit occupancy count 0..4.
REQ-016 SHALL push on a clk edge when wr_en=1 and occupancy<4; with occupancy=4, a push SHALL be dropped, SHALL leave the FIFO unchanged and SHALL set ovf.
REQ-017 SHALL pop into the 8-bit register when Load_Reg=0 and occupancy>0; the register SHALL take the head entry and Load_Reg SHALL rise one cycle after the edge on which data became available.
REQ-018 SHALL perform push and pop together on the same edge when both are enabled, leaving occupancy unchanged; at occupancy 4 with a pop on the same edge, the push SHALL be accepted.
REQ-019 SHALL, on Clear_Reg=1, clear Load_Reg and the register to 0 on the next edge; no pop SHALL occur on that edge, and the refill pop SHALL occur on the following edge.
REQ-020 SHALL, on Load_C=1, make count equal the register on the next edge; Load_C with Load_Reg=0 SHALL load 0.
REQ-021 SHALL, on Enable_C=1 with count>0, decrement count by 1; Enable_C with count=0 SHALL leave count at 0 with no wrap and no done.
REQ-022 SHALL assert done for exactly one cycle after the edge on which count transitions from 1 to 0.
REQ-023 SHALL give Load_C priority over Enable_C when both are asserted; Clear_Reg SHALL act independently of both.
REQ-024 SHALL drive EmptyBuffer = (count==0) combinationally from the count register.
REQ-025 SHALL drive full = (occupancy==4) combinationally.
REQ-026 SHALL assign each output exactly one driver; only done and ovf are flags beyond the stated datapath.

Reset
REQ-027 SHALL, while rst=1, immediately force the following independent of clk: pointers=0, occupancy=0, register=0, Load_Reg=0, count=0, done=0, ovf=0.
REQ-028 SHALL, during reset, hold EmptyBuffer=1 and full=0.
REQ-029 SHALL, if rst is asserted mid-count, discard FIFO contents and count without emitting done.
REQ-030 SHALL leave ovf cleared only by rst.

Verification
REQ-031 SHALL be covered by this scenario: push 0x03 after reset -> Load_Reg=1 two edges later; Load_C -> count=3, EmptyBuffer=0; 3x Enable_C -> count 2,1,0 with done high for one cycle after the third edge and EmptyBuffer=1.
REQ-032 SHALL be covered by this scenario: push 0x11,0x22,0x33,0x44,0x55 with no pops blocked (register occupied) -> after 0x11 moves to the register, the FIFO holds 0x22..0x55 with full=1; a sixth push sets ovf=1 and the contents are unchanged.
REQ-033 SHALL be covered by this scenario: FIFO full plus Clear_Reg, then a simultaneous push of 0x66 and pop -> the register takes the old head, occupancy stays 4, and 0x66 is the last entry out.
REQ-034 SHALL be covered by this scenario: Load_C and Enable_C both asserted with register=0x05 and count=0x09 -> count=0x05.
REQ-035 SHALL be covered by this scenario: Enable_C held for 3 cycles at count=0 -> count stays 0, done stays 0, no wrap to 0xFF.
REQ-036 SHALL be covered by this scenario: rst pulsed asynchronously, between clk edges, at count=0x02 with 2 FIFO entries -> all outputs return to their reset values before the next edge, done never asserts, and after release a new push is accepted normally.
